// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pkg
//  Description : Shared definitions for the memory arbiter slice: arbiter
//                state encoding, beat-counter width and the default number
//                of words in one cache-line fill.
//  Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    // Default number of 16-bit words per cache line fill.
    localparam int LINE_WORDS_DEFAULT = 8;

    // Width of the fill beat counter (covers up to 8 words per line).
    localparam int BEAT_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        I_FILL  = 2'd1,
        D_FILL  = 2'd2,
        D_WRITE = 2'd3
    } arb_state_e;

endpackage : arb_pkg
`default_nettype wire

// File: rtl/arb_beat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : arb_beat_counter
//  Description : Counts returned data beats of a cache-line fill and flags
//                the final beat of the line.
//  Ports       : clk       - clock, rising edge
//                rst_n     - asynchronous active-low reset
//                enable_i  - one routed data beat this cycle
//                clear_i   - return count to zero (wins over enable_i)
//                count_o   - beats received so far in the current fill
//                last_o    - count_o addresses the final word of the line
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_beat_counter
    import arb_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_i,
    input  logic              clear_i,
    output logic [BEAT_W-1:0] count_o,
    output logic              last_o
);

    localparam logic [BEAT_W-1:0] C_LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    logic [BEAT_W-1:0] count_q;
    logic [BEAT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + BEAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign last_o  = (count_q == C_LAST_BEAT);

endmodule : arb_beat_counter
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Arbitrates a single 16-bit memory port between the I-cache
//                line-fill engine and the D-cache line-fill / write-through
//                store path. A fill owns the port until its last beat returns
//                or the owner's busy drops; a store takes exactly one cycle.
//  Ports       : clk, rst_n                      - clock / async low reset
//                i_busy, i_read_req, i_addr      - I-cache fill request
//                d_busy, d_read_req, d_addr      - D-cache fill request
//                d_wr_req, d_wr_addr, d_wr_data  - D-cache store request
//                mem_data_out, mem_data_valid    - memory read return
//                mem_enable, mem_wr, mem_addr,
//                mem_data_in                     - memory command
//                i_data_valid, d_data_valid      - routed fill data valid
//                rd_data                         - read data to both caches
//                i_stall, d_stall                - request pending, no grant
//  Config      : ARB_ROUND_ROBIN_EN - when defined, simultaneous I and D fill
//                requests alternate between the caches; otherwise D has fixed
//                priority over I. A store always wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_busy,
    input  logic        i_read_req,
    input  logic [15:0] i_addr,
    input  logic        d_busy,
    input  logic        d_read_req,
    input  logic [15:0] d_addr,
    input  logic        d_wr_req,
    input  logic [15:0] d_wr_addr,
    input  logic [15:0] d_wr_data,
    input  logic [15:0] mem_data_out,
    input  logic        mem_data_valid,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_in,
    output logic        i_data_valid,
    output logic        d_data_valid,
    output logic [15:0] rd_data,
    output logic        i_stall,
    output logic        d_stall
);

    arb_state_e state_q;
    arb_state_e state_d;

    logic w_i_fill_req;
    logic w_d_fill_req;
    logic w_prefer_i;
    logic w_i_granted;
    logic w_d_granted;
    logic w_beat_en;
    logic w_beat_clr;
    logic w_beat_last;

    assign w_i_fill_req = i_busy & i_read_req;
    assign w_d_fill_req = d_busy & d_read_req;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = the most recent fill grant went to the D-cache.
    logic prio_q;
    logic prio_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

    assign w_prefer_i = prio_q;
`else
    assign w_prefer_i = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
`ifdef ARB_ROUND_ROBIN_EN
        prio_d       = prio_q;
`endif
        mem_enable   = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = 16'h0000;
        mem_data_in  = 16'h0000;
        i_data_valid = 1'b0;
        d_data_valid = 1'b0;
        w_i_granted  = 1'b0;
        w_d_granted  = 1'b0;
        w_beat_en    = 1'b0;
        w_beat_clr   = 1'b0;

        // The grant path is combinational, so it must be held off while
        // reset is asserted to keep every command output at zero.
        if (rst_n) begin
            unique case (state_q)
                IDLE: begin
                    // Memory data arriving here belongs to nobody and is
                    // dropped. A fill grant issues its first read this cycle.
                    if (d_wr_req) begin
                        state_d     = D_WRITE;
                        w_d_granted = 1'b1;
                    end else if (w_d_fill_req && !(w_i_fill_req && w_prefer_i)) begin
                        state_d     = D_FILL;
                        w_d_granted = 1'b1;
                        mem_enable  = 1'b1;
                        mem_addr    = d_addr;
`ifdef ARB_ROUND_ROBIN_EN
                        prio_d      = 1'b1;
`endif
                    end else if (w_i_fill_req) begin
                        state_d     = I_FILL;
                        w_i_granted = 1'b1;
                        mem_enable  = 1'b1;
                        mem_addr    = i_addr;
`ifdef ARB_ROUND_ROBIN_EN
                        prio_d      = 1'b0;
`endif
                    end
                end

                I_FILL: begin
                    w_i_granted  = 1'b1;
                    mem_enable   = i_read_req;
                    mem_addr     = i_addr;
                    i_data_valid = mem_data_valid;
                    w_beat_en    = mem_data_valid;
                    if (!i_busy || (mem_data_valid && w_beat_last)) begin
                        state_d    = IDLE;
                        w_beat_clr = 1'b1;
                    end
                end

                D_FILL: begin
                    w_d_granted  = 1'b1;
                    mem_enable   = d_read_req;
                    mem_addr     = d_addr;
                    d_data_valid = mem_data_valid;
                    w_beat_en    = mem_data_valid;
                    if (!d_busy || (mem_data_valid && w_beat_last)) begin
                        state_d    = IDLE;
                        w_beat_clr = 1'b1;
                    end
                end

                D_WRITE: begin
                    w_d_granted = 1'b1;
                    mem_enable  = 1'b1;
                    mem_wr      = 1'b1;
                    mem_addr    = d_wr_addr;
                    mem_data_in = d_wr_data;
                    state_d     = IDLE;
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    arb_beat_counter #(
        .LINE_WORDS (LINE_WORDS)
    ) u_beat_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable_i (w_beat_en),
        .clear_i  (w_beat_clr),
        .count_o  (),
        .last_o   (w_beat_last)
    );

    assign rd_data = mem_data_out;
    assign i_stall = rst_n & i_read_req & ~w_i_granted;
    assign d_stall = rst_n & (d_read_req | d_wr_req) & ~w_d_granted;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter. IDLE-cycle decisions
//                are applied from a vector table; fills, store-behind-fill,
//                arbitration order and reset-mid-fill are hand sequences.
//  Config      : ARB_ROUND_ROBIN_EN selects the alternating-grant expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_busy, i_read_req, d_busy, d_read_req, d_wr_req, mem_data_valid;
    logic [15:0] i_addr, d_addr, d_wr_addr, d_wr_data, mem_data_out;
    logic        mem_enable, mem_wr, i_data_valid, d_data_valid, i_stall, d_stall;
    logic [15:0] mem_addr, mem_data_in, rd_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.LINE_WORDS(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_busy         (i_busy),
        .i_read_req     (i_read_req),
        .i_addr         (i_addr),
        .d_busy         (d_busy),
        .d_read_req     (d_read_req),
        .d_addr         (d_addr),
        .d_wr_req       (d_wr_req),
        .d_wr_addr      (d_wr_addr),
        .d_wr_data      (d_wr_data),
        .mem_data_out   (mem_data_out),
        .mem_data_valid (mem_data_valid),
        .mem_enable     (mem_enable),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_data_in    (mem_data_in),
        .i_data_valid   (i_data_valid),
        .d_data_valid   (d_data_valid),
        .rd_data        (rd_data),
        .i_stall        (i_stall),
        .d_stall        (d_stall)
    );

    typedef struct {
        logic        i_busy, i_req;
        logic [15:0] i_addr;
        logic        d_busy, d_req;
        logic [15:0] d_addr;
        logic        d_wr;
        logic [15:0] wa, wd, mdo;
        logic        mdv;
        logic        en, wr;
        logic [15:0] addr, din;
        logic        idv, ddv, ist, dst;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        i_busy = 0; i_read_req = 0; i_addr = 0;
        d_busy = 0; d_read_req = 0; d_addr = 0;
        d_wr_req = 0; d_wr_addr = 0; d_wr_data = 0;
        mem_data_out = 0; mem_data_valid = 0;
    endtask

    // Returns at a falling edge with reset released and all inputs idle.
    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_cmd(input string nm, input logic en, input logic wr, input logic [15:0] addr);
        chk({nm, "_en"},   mem_enable, 16'(en));
        chk({nm, "_wr"},   mem_wr,     16'(wr));
        chk({nm, "_addr"}, mem_addr,   addr);
    endtask

    initial begin
        //            ib ir i_addr     db dr d_addr     w  wa        wd        mdo        v | en wr addr       din       idv ddv ist dst
        vecs[0] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0,  0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0};
        vecs[1] = '{1, 1, 16'h1230, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h1111, 0,  1, 0, 16'h1230, 16'h0000, 0, 0, 0, 0};
        vecs[2] = '{0, 0, 16'h0000, 1, 1, 16'h2000, 0, 16'h0000, 16'h0000, 16'h2222, 0,  1, 0, 16'h2000, 16'h0000, 0, 0, 0, 0};
        vecs[3] = '{1, 1, 16'h1000, 1, 1, 16'h2000, 0, 16'h0000, 16'h0000, 16'h3333, 0,  1, 0, 16'h2000, 16'h0000, 0, 0, 1, 0};
        vecs[4] = '{1, 1, 16'h1230, 0, 0, 16'h0000, 1, 16'h0040, 16'hBEEF, 16'h4444, 0,  0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0};
        vecs[5] = '{0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h5A5A, 1,  0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0};
        vecs[6] = '{0, 1, 16'h1230, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h6666, 0,  0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0};
        vecs[7] = '{0, 0, 16'h0000, 0, 1, 16'h2000, 0, 16'h0000, 16'h0000, 16'h7777, 1,  0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1};

        // ---------------- reset state: outputs zero, rd_data follows memory
        clear_inputs();
        rst_n = 1'b0;
        i_busy = 1; i_read_req = 1; i_addr = 16'h1230; mem_data_out = 16'hA5A5; mem_data_valid = 1;
        #2;
        chk_cmd("rst", 0, 0, 16'h0000);
        chk("rst_din", mem_data_in, 16'h0000);
        chk("rst_idv", i_data_valid, 16'h0);
        chk("rst_ist", i_stall, 16'h0);
        chk("rst_rd",  rd_data, 16'hA5A5);
        @(negedge clk);

        // ---------------- IDLE-cycle decision table
        for (int v = 0; v < 8; v++) begin
            do_reset();
            i_busy = vecs[v].i_busy; i_read_req = vecs[v].i_req; i_addr = vecs[v].i_addr;
            d_busy = vecs[v].d_busy; d_read_req = vecs[v].d_req; d_addr = vecs[v].d_addr;
            d_wr_req = vecs[v].d_wr; d_wr_addr = vecs[v].wa; d_wr_data = vecs[v].wd;
            mem_data_out = vecs[v].mdo; mem_data_valid = vecs[v].mdv;
            #1;
            chk($sformatf("vec%0d_en", v),   mem_enable,   16'(vecs[v].en));
            chk($sformatf("vec%0d_wr", v),   mem_wr,       16'(vecs[v].wr));
            chk($sformatf("vec%0d_addr", v), mem_addr,     vecs[v].addr);
            chk($sformatf("vec%0d_din", v),  mem_data_in,  vecs[v].din);
            chk($sformatf("vec%0d_idv", v),  i_data_valid, 16'(vecs[v].idv));
            chk($sformatf("vec%0d_ddv", v),  d_data_valid, 16'(vecs[v].ddv));
            chk($sformatf("vec%0d_rd", v),   rd_data,      vecs[v].mdo);
            chk($sformatf("vec%0d_ist", v),  i_stall,      16'(vecs[v].ist));
            chk($sformatf("vec%0d_dst", v),  d_stall,      16'(vecs[v].dst));
        end

        // ---------------- I fill alone at 0x1230, eight beats
        do_reset();
        i_busy = 1; i_read_req = 1; i_addr = 16'h1230;
        #1 chk_cmd("ifill_grant", 1, 0, 16'h1230);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            i_addr = 16'h1230 + 16'(2 * k);
            mem_data_valid = 1; mem_data_out = 16'h5000 + 16'(k);
            #1;
            chk($sformatf("ifill_b%0d_idv", k), i_data_valid, 16'h1);
            chk($sformatf("ifill_b%0d_ddv", k), d_data_valid, 16'h0);
            chk($sformatf("ifill_b%0d_addr", k), mem_addr, 16'h1230 + 16'(2 * k));
            chk($sformatf("ifill_b%0d_rd", k), rd_data, 16'h5000 + 16'(k));
        end
        @(negedge clk);
        i_busy = 0; i_read_req = 0; mem_data_valid = 1;
        #1;
        chk("ifill_done_idv", i_data_valid, 16'h0);
        chk("ifill_done_en", mem_enable, 16'h0);

        // ---------------- simultaneous fills: D first, I waits
        do_reset();
        i_busy = 1; i_read_req = 1; i_addr = 16'h1000;
        d_busy = 1; d_read_req = 1; d_addr = 16'h2000;
        #1;
        chk("both_addr", mem_addr, 16'h2000);
        chk("both_ist", i_stall, 16'h1);
        chk("both_dst", d_stall, 16'h0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            mem_data_valid = 1;
            #1;
            chk($sformatf("both_b%0d_ddv", k), d_data_valid, 16'h1);
            chk($sformatf("both_b%0d_idv", k), i_data_valid, 16'h0);
            chk($sformatf("both_b%0d_ist", k), i_stall, 16'h1);
        end
        @(negedge clk);
        d_busy = 0; d_read_req = 0; mem_data_valid = 0;
        #1;
        chk_cmd("both_igrant", 1, 0, 16'h1000);
        chk("both_igrant_ist", i_stall, 16'h0);
        @(negedge clk);
        mem_data_valid = 1;
        #1 chk("both_ifill_idv", i_data_valid, 16'h1);
        i_busy = 0;                      // owner abandons mid-fill
        @(negedge clk);
        #1 chk("abort_idv", i_data_valid, 16'h0);

        // ---------------- simultaneous fills after a D grant
        do_reset();
        d_busy = 1; d_read_req = 1; d_addr = 16'h2000;
        @(negedge clk);
        d_busy = 0; d_read_req = 0;
        @(negedge clk);
        i_busy = 1; i_read_req = 1; i_addr = 16'h1000;
        d_busy = 1; d_read_req = 1; d_addr = 16'h2000;
        #1;
`ifdef ARB_ROUND_ROBIN_EN
        chk("rr_addr", mem_addr, 16'h1000);
        chk("rr_ist", i_stall, 16'h0);
        chk("rr_dst", d_stall, 16'h1);
        @(negedge clk);
        mem_data_valid = 1;
        #1 chk("rr_idv", i_data_valid, 16'h1);
`else
        chk("fp_addr", mem_addr, 16'h2000);
        chk("fp_ist", i_stall, 16'h1);
        chk("fp_dst", d_stall, 16'h0);
        @(negedge clk);
        mem_data_valid = 1;
        #1 chk("fp_ddv", d_data_valid, 16'h1);
`endif

        // ---------------- store arriving during an I fill
        do_reset();
        i_busy = 1; i_read_req = 1; i_addr = 16'h1230;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            d_wr_req = 1; d_wr_addr = 16'h0040; d_wr_data = 16'hBEEF;
            mem_data_valid = 1;
            #1;
            chk($sformatf("wr_b%0d_dst", k), d_stall, 16'h1);
            chk($sformatf("wr_b%0d_wr", k), mem_wr, 16'h0);
        end
        @(negedge clk);
        i_busy = 0; i_read_req = 0; mem_data_valid = 0;
        #1;
        chk("wr_idle_dst", d_stall, 16'h0);
        chk("wr_idle_en", mem_enable, 16'h0);
        @(negedge clk);
        #1;
        chk_cmd("wr_cycle", 1, 1, 16'h0040);
        chk("wr_cycle_din", mem_data_in, 16'hBEEF);
        d_wr_req = 0;
        @(negedge clk);
        #1;
        chk_cmd("wr_after", 0, 0, 16'h0000);
        chk("wr_after_din", mem_data_in, 16'h0000);

        // ---------------- reset after beat 3 of a D fill
        do_reset();
        d_busy = 1; d_read_req = 1; d_addr = 16'h2000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mem_data_valid = 1;
        end
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("mrst_ddv", d_data_valid, 16'h0);
        chk("mrst_en", mem_enable, 16'h0);
        chk("mrst_dst", d_stall, 16'h0);
        @(negedge clk);
        rst_n = 1;
        #1 chk("mrst_idle_ddv", d_data_valid, 16'h0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1 chk($sformatf("mrst_b%0d_ddv", k), d_data_valid, 16'h1);
        end
        @(negedge clk);
        d_busy = 0; d_read_req = 0;
        #1 chk("mrst_done_ddv", d_data_valid, 16'h0);

        // ---------------- stray valid in IDLE leaves the arbiter idle
        do_reset();
        mem_data_valid = 1; mem_data_out = 16'h9999;
        #1 chk("stray_idv", i_data_valid, 16'h0);
        @(negedge clk);
        mem_data_valid = 0;
        i_busy = 1; i_read_req = 1; i_addr = 16'h3000;
        #1;
        chk_cmd("stray_next", 1, 0, 16'h3000);
        chk("stray_next_ist", i_stall, 16'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mem_arbiter
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 8, words per cache line fill.
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_busy  in  1  I-cache fill FSM busy
- i_read_req  in  1  I-cache fill read request
- i_addr  in  16  I-cache fill word address
- d_busy  in  1  D-cache fill FSM busy
- d_read_req  in  1  D-cache fill read request
- d_addr  in  16  D-cache fill word address
- d_wr_req  in  1  D-cache write-through store request
- d_wr_addr  in  16  store address
- d_wr_data  in  16  store data
- mem_data_out  in  16  memory read data
- mem_data_valid  in  1  memory read data valid
- mem_enable  out  1  memory access strobe
- mem_wr  out  1  memory write (1) / read (0)
- mem_addr  out  16  memory address
- mem_data_in  out  16  memory write data
- i_data_valid  out  1  fill data valid, routed to I-cache
- d_data_valid  out  1  fill data valid, routed to D-cache
- rd_data  out  16  mem_data_out forwarded to both caches
- i_stall  out  1  I-cache request pending, not granted
- d_stall  out  1  D-cache request pending, not granted

Function
REQ-003 SHALL implement states IDLE, I_FILL, D_FILL, D_WRITE.
REQ-004 IDLE: d_wr_req -> D_WRITE; else d_busy&d_read_req -> D_FILL; else i_busy&i_read_req -> I_FILL; else stay.
REQ-005 D_WRITE SHALL last exactly one cycle: mem_enable=1, mem_wr=1, mem_addr=d_wr_addr, mem_data_in=d_wr_data; then IDLE.
REQ-006 Entry into I_FILL/D_FILL SHALL be combinational in the IDLE cycle: the first read issues that same cycle (mem_enable=1, mem_wr=0, mem_addr=owner addr).
REQ-007 In a fill state: mem_enable=owner read_req, mem_wr=0, mem_addr=owner addr; non-owner requests ignored.
REQ-008 Owner data valid = mem_data_valid & state matches owner; other valid output = 0.
REQ-009 A 3-bit beat counter SHALL increment on each routed mem_data_valid; on beat LINE_WORDS-1 valid -> IDLE, counter -> 0.
REQ-010 Owner busy deasserting mid-fill SHALL force IDLE and clear the counter the next edge.
REQ-011 i_stall = i_read_req & !(state==I_FILL or IDLE-grant to I); d_stall likewise for d_read_req|d_wr_req.
REQ-012 rd_data SHALL equal mem_data_out at all times.
REQ-013 mem_data_valid in IDLE or D_WRITE SHALL be dropped (neither valid asserted).
REQ-014 Outside active access: mem_enable=0, mem_wr=0, mem_addr=0, mem_data_in=0.

Reset
REQ-015 rst_n low SHALL immediately force IDLE, counter=0, priority bit=0; all outputs 0 except rd_data (follows memory).
REQ-016 Reset mid-fill SHALL abandon the fill; no data valid asserted until a new grant.

Configuration
REQ-017 ARB_ROUND_ROBIN_EN defined: on simultaneous I and D fill requests in IDLE, grant the cache not granted last (priority bit updated per fill grant); d_wr_req still wins.
REQ-018 ARB_ROUND_ROBIN_EN undefined: fixed priority D write > D fill > I fill; priority bit absent.

Structure
REQ-019 Shared package arb_pkg SHALL hold state encoding and LINE_WORDS default.
REQ-020 Beat counter SHALL be sub-module arb_beat_counter (enable, clear, count, last).

Verification
REQ-021 I fill alone at 0x1230, 8 valids -> i_data_valid 8 pulses, addrs 0x1230..0x123E, IDLE after 8th.
REQ-022 I and D fill requests same cycle (no macro) -> D_FILL granted, i_stall=1 until D's 8th beat, then I_FILL.
REQ-023 Same with ARB_ROUND_ROBIN_EN, last grant D -> I_FILL granted, d_stall=1.
REQ-024 d_wr_req addr 0x0040 data 0xBEEF during I_FILL -> d_stall=1 until I done, then one-cycle write, mem_wr=1.
REQ-025 rst_n low after beat 3 of D fill -> IDLE, d_data_valid=0, next fill counts from beat 0.
REQ-026 mem_data_valid pulse in IDLE -> no valid output, state unchanged.
